// File: rtl/seg7_write_arbiter.sv
// Round-robin arbiter sharing the 7-segment display among four requesters.
// Each update is two atomic byte writes on the shared bus (low byte, then high byte).
module seg7_write_arbiter #(
    parameter logic [7:0]  SEG7_BASE_ADDR = 8'hD0,
    parameter logic [15:0] MIN_HOLD       = 16'd1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  REQ,
    input  logic [63:0] REQ_VALUE,
    output logic [3:0]  ACK,
    output logic        BUS_REQ,
    input  logic        BUS_GNT,
    output logic [7:0]  BUS_ADDR,
    output logic [7:0]  BUS_DATA,
    output logic        BUS_WE,
    output logic        BUSY,
    output logic [1:0]  LAST_SRC,
    output logic [2:0]  DBG_STATE
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_GNT = 3'd1,
        WR_LO    = 3'd2,
        WR_HI    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] value_q, value_d;
    logic [1:0]  src_q, src_d;
    logic [1:0]  last_q, last_d;

    logic [3:0]  ack_q, ack_d;
    logic        bus_req_q, bus_req_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;

    logic [1:0]  win_c;
    logic        found_c;

    // Search starts just after the last winner, so the previous winner is checked last.
    always_comb begin : pick
        found_c = 1'b0;
        win_c   = last_q + 2'd1;
        for (int k = 1; k <= 4; k++) begin
            if (!found_c && REQ[last_q + 2'(k)]) begin
                found_c = 1'b1;
                win_c   = last_q + 2'(k);
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        value_d = value_q;
        src_d   = src_q;
        last_d  = last_q;
        hold_d  = (hold_q != 16'd0) ? hold_q - 16'd1 : hold_q;
        case (state_q)
            IDLE: begin
                if (hold_q == 16'd0 && found_c) begin
                    state_d = WAIT_GNT;
                    value_d = REQ_VALUE[{win_c, 4'd0} +: 16];
                    src_d   = win_c;
                end
            end
            WAIT_GNT: begin
                if (BUS_GNT) state_d = WR_LO;
            end
            // Once writing has started the sequence always runs to completion.
            WR_LO: state_d = WR_HI;
            WR_HI: begin
                state_d = DONE;
                last_d  = src_q;
            end
            DONE: begin
                state_d = IDLE;
                hold_d  = MIN_HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are all plain registers.
    always_comb begin : out_next
        ack_d     = 4'd0;
        bus_req_d = 1'b0;
        addr_d    = 8'd0;
        data_d    = 8'd0;
        we_d      = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_d)
            WAIT_GNT: bus_req_d = 1'b1;
            WR_LO: begin
                bus_req_d = 1'b1;
                we_d      = 1'b1;
                addr_d    = SEG7_BASE_ADDR;
                data_d    = value_d[7:0];
            end
            WR_HI: begin
                bus_req_d = 1'b1;
                we_d      = 1'b1;
                addr_d    = SEG7_BASE_ADDR + 8'd1;
                data_d    = value_d[15:8];
            end
            DONE: ack_d = 4'b0001 << src_d;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            hold_q    <= 16'd0;
            value_q   <= 16'd0;
            src_q     <= 2'd0;
            last_q    <= 2'd3;
            ack_q     <= 4'd0;
            bus_req_q <= 1'b0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            value_q   <= value_d;
            src_q     <= src_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            bus_req_q <= bus_req_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
        end
    end

    assign ACK       = ack_q;
    assign BUS_REQ   = bus_req_q;
    assign BUS_ADDR  = addr_q;
    assign BUS_DATA  = data_q;
    assign BUS_WE    = we_q;
    assign BUSY      = busy_q;
    assign LAST_SRC  = last_q;
    assign DBG_STATE = state_q;

endmodule
